// File: rtl/shift_reg_pkg.sv
// Shared encodings for the shift-register checker and its stimulus modules.
package shift_reg_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic ENABLE = 1'b1;
    localparam logic LOW    = 1'b0;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        LOGIC_SHIFT = 2'b00,
        CIRC_SHIFT  = 2'b01,
        PARA_LOAD   = 2'b10,
        HOLD        = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        UNSYNC = 2'b00,
        TRACK  = 2'b01,
        FAILED = 2'b10
    } state_e;

endpackage

// File: rtl/shift_reg_model.sv
// Combinational next-state function of the reference shift register:
// next register value and the serial bit ejected by the last shift.
module shift_reg_model
    import shift_reg_pkg::*;
(
    input  logic              enb_i,
    input  logic              dir_i,
    input  logic              s_in_i,
    input  logic [1:0]        modo_i,
    input  logic [DATA_W-1:0] d_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic              sout_i,
    output logic [DATA_W-1:0] q_nxt_c_o,
    output logic              sout_nxt_c_o
);

    always_comb begin
        q_nxt_c_o    = q_i;
        sout_nxt_c_o = sout_i;
        if (enb_i == ENABLE) begin
            unique case (mode_e'(modo_i))
                LOGIC_SHIFT: begin
                    q_nxt_c_o    = dir_i ? {s_in_i, q_i[DATA_W-1:1]} : {q_i[DATA_W-2:0], s_in_i};
                    sout_nxt_c_o = dir_i ? q_i[0] : q_i[DATA_W-1];
                end
                CIRC_SHIFT: begin
                    q_nxt_c_o    = dir_i ? {q_i[0], q_i[DATA_W-1:1]} : {q_i[DATA_W-2:0], q_i[DATA_W-1]};
                    sout_nxt_c_o = dir_i ? q_i[0] : q_i[DATA_W-1];
                end
                PARA_LOAD: begin
                    q_nxt_c_o    = d_i;
                    sout_nxt_c_o = LOW;
                end
                HOLD: begin
                    q_nxt_c_o    = q_i;
                    sout_nxt_c_o = sout_i;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_reg_checker.sv
// Reference-model checker for a 4-bit universal shift register.
// Define CHECKER_SOUT_EN to also model and compare the serial output.
module shift_reg_checker
    import shift_reg_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ENB,
    input  logic              DIR,
    input  logic              S_IN,
    input  logic [1:0]        MODO,
    input  logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q,
    input  logic              S_OUT,
    output logic [DATA_W-1:0] MODEL_Q,
`ifdef CHECKER_SOUT_EN
    output logic              MODEL_S_OUT,
`endif
    output logic              CHECK_VALID,
    output logic              MISMATCH,
    output logic              FAIL,
    output logic [CNT_W-1:0]  ERR_CNT
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  model_q_q, model_q_d;
    logic               check_valid_q, check_valid_d;
    logic               mismatch_q, mismatch_d;
    logic               fail_q, fail_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0]  q_nxt_c;
    logic               sout_nxt_c;
    logic               sout_cur_c;
    logic               diff_c;

`ifdef CHECKER_SOUT_EN
    logic               model_sout_q, model_sout_d;
    assign sout_cur_c  = model_sout_q;
    assign diff_c      = (Q != model_q_q) || (S_OUT != model_sout_q);
    assign MODEL_S_OUT = model_sout_q;
`else
    logic               unused_sout;
    assign sout_cur_c  = LOW;
    assign diff_c      = (Q != model_q_q);
    assign unused_sout = ^{S_OUT, sout_nxt_c};
`endif

    shift_reg_model u_model (
        .enb_i        (ENB),
        .dir_i        (DIR),
        .s_in_i       (S_IN),
        .modo_i       (MODO),
        .d_i          (D),
        .q_i          (model_q_q),
        .sout_i       (sout_cur_c),
        .q_nxt_c_o    (q_nxt_c),
        .sout_nxt_c_o (sout_nxt_c)
    );

    // Next-state: sync on a parallel load, then track and compare pre-edge values
    always_comb begin
        state_d      = state_q;
        model_q_d    = model_q_q;
        mismatch_d   = 1'b0;
        err_cnt_d    = err_cnt_q;
`ifdef CHECKER_SOUT_EN
        model_sout_d = model_sout_q;
`endif
        unique case (state_q)
            UNSYNC: begin
                if (ENB == ENABLE && mode_e'(MODO) == PARA_LOAD) begin
                    state_d   = TRACK;
                    model_q_d = q_nxt_c;
`ifdef CHECKER_SOUT_EN
                    model_sout_d = sout_nxt_c;
`endif
                end
            end
            TRACK, FAILED: begin
                model_q_d = q_nxt_c;
`ifdef CHECKER_SOUT_EN
                model_sout_d = sout_nxt_c;
`endif
                if (diff_c) begin
                    mismatch_d = 1'b1;
                    state_d    = FAILED;
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = UNSYNC;
        endcase
        check_valid_d = (state_d != UNSYNC);
        fail_d        = (state_d == FAILED);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= UNSYNC;
            model_q_q     <= '0;
            check_valid_q <= 1'b0;
            mismatch_q    <= 1'b0;
            fail_q        <= 1'b0;
            err_cnt_q     <= '0;
`ifdef CHECKER_SOUT_EN
            model_sout_q  <= LOW;
`endif
        end else begin
            state_q       <= state_d;
            model_q_q     <= model_q_d;
            check_valid_q <= check_valid_d;
            mismatch_q    <= mismatch_d;
            fail_q        <= fail_d;
            err_cnt_q     <= err_cnt_d;
`ifdef CHECKER_SOUT_EN
            model_sout_q  <= model_sout_d;
`endif
        end
    end

    assign MODEL_Q     = model_q_q;
    assign CHECK_VALID = check_valid_q;
    assign MISMATCH    = mismatch_q;
    assign FAIL        = fail_q;
    assign ERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_shift_reg_checker.sv
// Directed + randomized bench for shift_reg_checker against an arithmetic reference model.
`timescale 1ns/1ps
module tb_shift_reg_checker;
    import shift_reg_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enb, dir, s_in, s_out;
    logic [1:0] modo;
    logic [3:0] d, q;
    logic [3:0] model_q;
    logic       check_valid, mismatch, fail_o;
    logic [7:0] err_cnt;
`ifdef CHECKER_SOUT_EN
    localparam bit SOUT_EN = 1'b1;
    logic       model_s_out;
`else
    localparam bit SOUT_EN = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    // reference model state
    bit m_valid, m_fail, m_mis;
    int m_q, m_sout, m_cnt;

    logic [3:0] seq034 [5] = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [3:0] seq035 [5] = '{4'h8, 4'hC, 4'hE, 4'hF, 4'hF};
    logic       sout035 [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    shift_reg_checker dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .ENB         (enb),
        .DIR         (dir),
        .S_IN        (s_in),
        .MODO        (modo),
        .D           (d),
        .Q           (q),
        .S_OUT       (s_out),
        .MODEL_Q     (model_q),
`ifdef CHECKER_SOUT_EN
        .MODEL_S_OUT (model_s_out),
`endif
        .CHECK_VALID (check_valid),
        .MISMATCH    (mismatch),
        .FAIL        (fail_o),
        .ERR_CNT     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_fail = 0; m_mis = 0;
        m_q = 0; m_sout = 0; m_cnt = 0;
    endtask

    // One rising edge of the reference: uses the currently driven (pre-edge) inputs
    task automatic model_edge();
        int nq, ns;
        bit mis;
        mis = 0; nq = m_q; ns = m_sout;
        if (!m_valid) begin
            if (enb && modo == PARA_LOAD) begin
                m_valid = 1; nq = int'(d); ns = 0;
            end
        end else begin
            mis = (int'(q) != m_q) || (SOUT_EN && int'(s_out) != m_sout);
            if (mis) begin
                m_fail = 1;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
            if (enb) begin
                case (modo)
                    LOGIC_SHIFT: begin
                        if (!dir) begin ns = m_q / 8; nq = (m_q * 2) % 16 + int'(s_in); end
                        else      begin ns = m_q % 2; nq = m_q / 2 + 8 * int'(s_in); end
                    end
                    CIRC_SHIFT: begin
                        if (!dir) begin ns = m_q / 8; nq = (m_q * 2) % 16 + m_q / 8; end
                        else      begin ns = m_q % 2; nq = m_q / 2 + 8 * (m_q % 2); end
                    end
                    PARA_LOAD: begin nq = int'(d); ns = 0; end
                    default: ;
                endcase
            end
        end
        m_q = nq; m_sout = ns; m_mis = mis;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_model_q"}, 32'(model_q), 32'(m_q));
        chk({tag, "_valid"}, 32'(check_valid), 32'(m_valid));
        chk({tag, "_mis"}, 32'(mismatch), 32'(m_mis));
        chk({tag, "_fail"}, 32'(fail_o), 32'(m_fail));
        chk({tag, "_cnt"}, 32'(err_cnt), 32'(m_cnt));
`ifdef CHECKER_SOUT_EN
        chk({tag, "_sout"}, 32'(model_s_out), 32'(m_sout));
`endif
    endtask

    // Drive one cycle; the observed Q is the expected value XOR qerr
    task automatic cyc(input string tag, input logic enb_v, input logic dir_v, input logic sin_v,
                       input logic [1:0] modo_v, input logic [3:0] d_v, input logic [3:0] qerr);
        enb = enb_v; dir = dir_v; s_in = sin_v; modo = modo_v; d = d_v;
        q = 4'(m_q) ^ qerr;
        s_out = m_sout[0];
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Assert reset mid-cycle, check outputs clear before the next edge, release mid-cycle
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; enb = 0; dir = 0; s_in = 0; s_out = 0; modo = 2'b00; d = 4'h0; q = 4'h0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // no prior parallel load: nothing tracked, whatever Q shows
        cyc("nosync_pl_off", 1'b0, 1'b0, 1'b0, PARA_LOAD, 4'h5, 4'h3);
        for (int i = 0; i < 4; i++)
            cyc("nosync", 1'b1, 1'($urandom), 1'($urandom), CIRC_SHIFT, 4'($urandom), 4'($urandom));
        chk("nosync_valid", 32'(check_valid), 32'd0);
        chk("nosync_cnt", 32'(err_cnt), 32'd0);

        // load 1000 then rotate left
        cyc("circ_load", 1'b1, 1'b0, 1'b0, PARA_LOAD, 4'h8, 4'h0);
        chk("circ_seq0", 32'(model_q), 32'(seq034[0]));
        chk("circ_valid", 32'(check_valid), 32'd1);
        for (int i = 1; i < 5; i++) begin
            cyc("circ", 1'b1, 1'b0, 1'($urandom), CIRC_SHIFT, 4'($urandom), 4'h0);
            chk("circ_seq", 32'(model_q), 32'(seq034[i]));
        end
        chk("circ_cnt", 32'(err_cnt), 32'd0);

        // logical right shift of ones into 0000
        cyc("lsr_load", 1'b1, 1'b1, 1'b0, PARA_LOAD, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            cyc("lsr", 1'b1, 1'b1, 1'b1, LOGIC_SHIFT, 4'h0, 4'h0);
            chk("lsr_seq", 32'(model_q), 32'(seq035[i]));
`ifdef CHECKER_SOUT_EN
            chk("lsr_sout", 32'(model_s_out), 32'(sout035[i]));
`endif
        end

        // enable low holds the register in every mode
        cyc("hold_load", 1'b1, 1'b0, 1'b0, PARA_LOAD, 4'hA, 4'h0);
        for (int i = 0; i < 5; i++)
            cyc("enb_off", 1'b0, 1'($urandom), 1'($urandom), CIRC_SHIFT, 4'($urandom), 4'h0);
        chk("enb_off_q", 32'(model_q), 32'hA);
        chk("enb_off_mis", 32'(mismatch), 32'd0);

        // random traffic from a correct device
        for (int i = 0; i < 200; i++)
            cyc("rand_ok", 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 4'h0);
        chk("rand_ok_fail", 32'(fail_o), 32'd0);
        chk("rand_ok_cnt", 32'(err_cnt), 32'd0);

        // single divergence: Q=0101 while 0100 is expected
        cyc("div_load", 1'b1, 1'b0, 1'b0, PARA_LOAD, 4'h4, 4'h0);
        cyc("div_hit", 1'b1, 1'b0, 1'b0, HOLD, 4'h0, 4'h1);
        chk("div_mis_hi", 32'(mismatch), 32'd1);
        chk("div_cnt", 32'(err_cnt), 32'd1);
        chk("div_fail", 32'(fail_o), 32'd1);
        cyc("div_after", 1'b1, 1'b0, 1'b0, HOLD, 4'h0, 4'h0);
        chk("div_mis_lo", 32'(mismatch), 32'd0);
        chk("div_fail_sticky", 32'(fail_o), 32'd1);

        // mismatch and mode change on the same edge
        cyc("same_edge", 1'b1, 1'b0, 1'b0, PARA_LOAD, 4'h3, 4'h2);
        chk("same_edge_q", 32'(model_q), 32'h3);
        chk("same_edge_mis", 32'(mismatch), 32'd1);

        // random traffic with occasional errors
        for (int i = 0; i < 100; i++)
            cyc("rand_err", 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom),
                ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);

        // persistent mismatch saturates the counter
        for (int i = 0; i < 300; i++)
            cyc("persist", 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 4'hF);
        chk("sat_cnt", 32'(err_cnt), 32'd255);

        // reset mid-sequence discards tracking
        do_reset();
        for (int i = 0; i < 3; i++)
            cyc("post_rst", 1'b1, 1'($urandom), 1'($urandom), CIRC_SHIFT, 4'($urandom), 4'($urandom));
        chk("post_rst_valid", 32'(check_valid), 32'd0);
        cyc("resync", 1'b1, 1'b0, 1'b0, PARA_LOAD, 4'h6, 4'h0);
        chk("resync_valid", 32'(check_valid), 32'd1);
        chk("resync_q", 32'(model_q), 32'h6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_reg_checker.md
SHIFT_REG_CHECKER -- requirements
Module: shift_reg_checker

Interface
REQ-001 The block SHALL have these ports: CLK, input, 1, system clock, all state updates on rising edge.
REQ-002 The block SHALL have these ports: RST_N, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have these ports: ENB, input, 1, register enable stimulus; active when equal to `ENABLE (1'b1).
REQ-004 The block SHALL have these ports: DIR, input, 1, shift direction stimulus; 0 = left (toward MSB), 1 = right.
REQ-005 The block SHALL have these ports: S_IN, input, 1, serial-in stimulus.
REQ-006 The block SHALL have these ports: MODO, input, 2, mode stimulus: 00 LOGIC_SHIFT, 01 CIRC_SHIFT, 10 PARA_LOAD, 11 HOLD.
REQ-007 The block SHALL have these ports: D, input, 4, parallel-load data stimulus.
REQ-008 The block SHALL have these ports: Q, input, 4, observed register output from the device under check.
REQ-009 The block SHALL have these ports: S_OUT, input, 1, observed serial output from the device under check.
REQ-010 The block SHALL have these ports: MODEL_Q, output, 4, expected register value.
REQ-011 The block SHALL have these ports: CHECK_VALID, output, 1, high while the model is synchronised and comparisons are active.
REQ-012 The block SHALL have these ports: MISMATCH, output, 1, one-cycle pulse per detected divergence.
REQ-013 The block SHALL have these ports: FAIL, output, 1, sticky failure flag.
REQ-014 The block SHALL have these ports: ERR_CNT, output, 8, saturating mismatch count.

Function
REQ-015 The FSM SHALL have states UNSYNC, TRACK and FAILED, and SHALL start in UNSYNC.
REQ-016 In UNSYNC, an edge with ENB active and MODO = PARA_LOAD SHALL load MODEL_Q <= D and move the FSM to TRACK.
- CHECK_VALID SHALL rise on that same edge.
- All other edges in UNSYNC SHALL be ignored.
REQ-017 In TRACK or FAILED with ENB active, MODEL_Q SHALL update as follows:
- LOGIC_SHIFT left: {Q[2:0],S_IN}; right: {S_IN,Q[3:1]}.
- CIRC_SHIFT left: {Q[2:0],Q[3]}; right: {Q[0],Q[3:1]}.
- PARA_LOAD: D.
- HOLD: unchanged.
REQ-018 With ENB inactive, MODEL_Q SHALL hold in every mode.
REQ-019 The expected serial output SHALL be the bit ejected by the last shift: Q[3] for a left shift, Q[0] for a right shift.
- The expected serial output SHALL be 0 after PARA_LOAD.
- The expected serial output SHALL hold otherwise.
REQ-020 At each rising edge while CHECK_VALID = 1, the pre-edge Q (and S_OUT, per REQ-030) SHALL be compared with the pre-edge model value.
- The registered result SHALL drive MISMATCH.
- Latency SHALL be one cycle from divergence to MISMATCH.
REQ-021 On a mismatch, ERR_CNT SHALL increment by 1, saturating at 255 and never wrapping.
- On a mismatch, the FSM SHALL enter FAILED, where FAIL = 1 and tracking continues.
REQ-022 FAILED SHALL be left only by reset.
REQ-023 The comparison on the synchronising edge of REQ-016 SHALL NOT be counted.
REQ-024 If MODO changes on the same edge as a mismatch, both the mismatch and the new-mode model update SHALL take effect on that edge.

Reset
REQ-025 Asserting RST_N low SHALL immediately set MODEL_Q = 0000, the expected serial output = 0, CHECK_VALID = 0, MISMATCH = 0, FAIL = 0, ERR_CNT = 0 and the FSM to UNSYNC, without waiting for CLK.
REQ-026 Reset asserted mid-sequence SHALL discard all tracking; resynchronisation SHALL require a new PARA_LOAD.
REQ-027 Release of RST_N SHALL take effect at the first rising CLK edge after deassertion.

Configuration
REQ-028 The macro CHECKER_SOUT_EN SHALL control serial-output checking.
REQ-029 When CHECKER_SOUT_EN is defined, the block SHALL have an extra output MODEL_S_OUT (1 bit, expected serial output).
REQ-030 When CHECKER_SOUT_EN is defined, an S_OUT difference SHALL count as a mismatch.
REQ-031 When CHECKER_SOUT_EN is undefined, the MODEL_S_OUT port and its register SHALL be absent and only Q SHALL be compared.

Structure
REQ-032 The mode encodings (LOGIC_SHIFT, CIRC_SHIFT, PARA_LOAD, HOLD), ENABLE/LOW constants and FSM state encodings SHALL live in the shared package shift_reg_pkg, which is also used by the stimulus modules.
REQ-033 The next-state function of REQ-017 and REQ-019 SHALL be a separate combinational sub-module shift_reg_model, instantiated once.

Verification
REQ-034 Scenario: reset; ENB=1, D=1000, PARA_LOAD for 1 cycle, then CIRC_SHIFT, DIR=0, correct DUT -> MODEL_Q 1000,0001,0010,0100,1000; ERR_CNT stays 0.
REQ-035 Scenario: after sync, LOGIC_SHIFT right, S_IN=1, from Q=0000 -> MODEL_Q 1000,1100,1110,1111; with CHECKER_SOUT_EN, expected serial output = 0,0,0,0 then 1.
REQ-036 Scenario: force DUT Q=0101 when the model expects 0100 -> MISMATCH pulses for exactly 1 cycle, one cycle later; ERR_CNT=1; FAIL=1 and stays 1.
REQ-037 Scenario: ENB=0 with CIRC_SHIFT for 5 cycles after loading 1010 -> MODEL_Q stays 1010, no mismatch.
REQ-038 Scenario: persistent mismatch for 300 cycles -> ERR_CNT=255 (saturated); RST_N pulse low mid-cycle -> all outputs 0 before the next CLK edge and CHECK_VALID=0 until the next PARA_LOAD.
REQ-039 Scenario: CIRC_SHIFT with no prior PARA_LOAD -> CHECK_VALID=0 and ERR_CNT=0 regardless of Q.
